// File: rtl/clk_active_ctrl.sv
// Activity controller for the downstream clock-gating wrapper: turns req/busy/force_on demand into a registered active level with idle hysteresis.
// Latency: active rises one edge after demand is seen in OFF; clk_ready follows WAKE_CYCLES edges later; active drops IDLE_CYCLES edges after demand ends.
// Backpressure: none; demand is a level that is sampled every edge, and COOL ignores it until the minimum off time has elapsed.
module clk_active_ctrl #(
  parameter int CW             = 8,
  parameter int WAKE_CYCLES    = 4,
  parameter int IDLE_CYCLES    = 16,
  parameter int MIN_OFF_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       busy,
  input  logic       force_on,
  output logic       active,
  output logic       clk_ready,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_WAKE   = 3'd1,
    ST_ON     = 3'd2,
    ST_LINGER = 3'd3,
    ST_COOL   = 3'd4
  } state_e;

  // Reload values are truncated to the counter width; legal parameters always fit.
  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LD = CW'(MIN_OFF_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          ready_q, ready_d;
  logic          dmd;
  logic          cnt_zero;

  assign dmd      = req | busy | force_on;
  assign cnt_zero = (cnt_q == '0);

  // Next state, counter and Moore outputs; outputs are decoded from the next
  // state so that they are registered alongside it with no input-to-output path.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = 1'b0;
    ready_d  = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (dmd) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LD;
        end
      end

      // The wake sequence always runs to completion, even if demand drops,
      // so that clk_ready only ever reports a clock that is really running.
      ST_WAKE: begin
        if (cnt_zero) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_ON: begin
        if (!dmd) begin
          state_d = ST_LINGER;
          cnt_d   = IDLE_LD;
        end
      end

      // Any demand returns to ON; the idle count restarts on the next entry.
      ST_LINGER: begin
        if (dmd) begin
          state_d = ST_ON;
        end else if (cnt_zero) begin
          state_d = ST_COOL;
          cnt_d   = COOL_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // Demand is deliberately ignored until the minimum off time expires.
      ST_COOL: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (dmd) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LD;
        end else begin
          state_d = ST_OFF;
        end
      end

      // Unused encodings recover to OFF with both outputs low.
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase

    active_d = (state_d == ST_WAKE) || (state_d == ST_ON) || (state_d == ST_LINGER);
    ready_d  = (state_d == ST_ON) || (state_d == ST_LINGER);
  end

  // State, counter and output registers; reset forces OFF immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      active_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      ready_q  <= ready_d;
    end
  end

  assign active    = active_q;
  assign clk_ready = ready_q;
  assign state     = state_q;

endmodule

// File: tb/tb_clk_active_ctrl.sv
// Directed bench for clk_active_ctrl with default parameters.
// Latency: expected values are hand-derived per clock edge.
// Backpressure: not applicable; inputs are levels driven just after each edge.
module tb_clk_active_ctrl;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       req      = 1'b0;
  logic       busy     = 1'b0;
  logic       force_on = 1'b0;
  logic       active;
  logic       clk_ready;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  clk_active_ctrl #(
    .CW             (8),
    .WAKE_CYCLES    (4),
    .IDLE_CYCLES    (16),
    .MIN_OFF_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .busy      (busy),
    .force_on  (force_on),
    .active    (active),
    .clk_ready (clk_ready),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect3(input string tag, input int st, input int act, input int rdy);
    chk({tag, "/state"}, int'(state), st);
    chk({tag, "/active"}, int'(active), act);
    chk({tag, "/clk_ready"}, int'(clk_ready), rdy);
  endtask

  // Advance past the next rising edge and settle for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with req held high; outputs must be low at once and stay low.
    req = 1'b1;
    #1 rst_n = 1'b0;
    #1 expect3("rst_async", 0, 0, 0);
    step();
    expect3("rst_hold_a", 0, 0, 0);
    step();
    expect3("rst_hold_b", 0, 0, 0);
    #6 rst_n = 1'b1;

    // Wake: active after edge 0, clk_ready after edge 4.
    step();
    expect3("t1_e0", 1, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      expect3($sformatf("t1_e%0d", i), 1, 1, 0);
    end
    step();
    expect3("t1_e4", 2, 1, 1);
    for (int i = 5; i <= 9; i++) begin
      step();
      expect3($sformatf("t1_on_e%0d", i), 2, 1, 1);
    end

    // Drop req at edge 10: LINGER through edge 25, COOL at 26-27, OFF at 28.
    req = 1'b0;
    for (int i = 10; i <= 25; i++) begin
      step();
      expect3($sformatf("t2_e%0d", i), 3, 1, 1);
    end
    step();
    expect3("t2_e26", 4, 0, 0);
    step();
    expect3("t2_e27", 4, 0, 0);
    step();
    expect3("t2_e28", 0, 0, 0);

    // Wake again, then a one-cycle busy pulse at the 10th idle cycle.
    req = 1'b1;
    step();
    expect3("t3_wake0", 1, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      expect3($sformatf("t3_wake%0d", i), 1, 1, 0);
    end
    step();
    expect3("t3_on", 2, 1, 1);
    req = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      expect3($sformatf("t3_idle%0d", i), 3, 1, 1);
    end
    busy = 1'b1;
    step();
    expect3("t3_busy_back_on", 2, 1, 1);
    busy = 1'b0;
    for (int i = 0; i <= 15; i++) begin
      step();
      expect3($sformatf("t3_relinger%0d", i), 3, 1, 1);
    end
    step();
    expect3("t3_fall", 4, 0, 0);

    // req re-asserted the cycle after COOL entry: two low cycles, then WAKE.
    req = 1'b1;
    step();
    expect3("t4_cool_hold", 4, 0, 0);
    step();
    expect3("t4_rewake0", 1, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      expect3($sformatf("t4_rewake%0d", i), 1, 1, 0);
    end
    step();
    expect3("t4_ready", 2, 1, 1);

    // Walk back down to OFF.
    req = 1'b0;
    for (int i = 0; i <= 15; i++) begin
      step();
      expect3($sformatf("t5_down%0d", i), 3, 1, 1);
    end
    step();
    expect3("t5_cool0", 4, 0, 0);
    step();
    expect3("t5_cool1", 4, 0, 0);
    step();
    expect3("t5_off", 0, 0, 0);
    step();
    expect3("t5_off_idle", 0, 0, 0);

    // One-cycle req pulse from OFF: full wake, linger, cool, off.
    req = 1'b1;
    step();
    expect3("t5_p_wake0", 1, 1, 0);
    req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      expect3($sformatf("t5_p_wake%0d", i), 1, 1, 0);
    end
    step();
    expect3("t5_p_on", 2, 1, 1);
    for (int i = 0; i <= 15; i++) begin
      step();
      expect3($sformatf("t5_p_linger%0d", i), 3, 1, 1);
    end
    step();
    expect3("t5_p_cool0", 4, 0, 0);
    step();
    expect3("t5_p_cool1", 4, 0, 0);
    step();
    expect3("t5_p_off", 0, 0, 0);

    // force_on alone: wake delay honoured, then ON held for 100 cycles.
    force_on = 1'b1;
    step();
    expect3("t6_wake0", 1, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      expect3($sformatf("t6_wake%0d", i), 1, 1, 0);
    end
    step();
    expect3("t6_on", 2, 1, 1);
    for (int i = 0; i < 100; i++) begin
      step();
      expect3($sformatf("t6_hold%0d", i), 2, 1, 1);
    end

    // Asynchronous reset mid-run, away from the clock edge.
    #3 rst_n = 1'b0;
    #1 expect3("t6_rst_async", 0, 0, 0);
    step();
    expect3("t6_rst_hold", 0, 0, 0);
    force_on = 1'b0;
    rst_n    = 1'b1;
    step();
    expect3("t6_post_rst0", 0, 0, 0);
    step();
    expect3("t6_post_rst1", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
